// File: rtl/pe_ctx_sequencer.sv
// Context-memory sequencer for a combinational processing element: issues one
// 18-bit context word per cycle over ctx_len+1 entries, repeated iter_count times.
module pe_ctx_sequencer #(
  parameter int CTX_DEPTH = 16,
  parameter int ITER_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [17:0]       cfg_data,
  input  logic [3:0]        ctx_len,
  input  logic [ITER_W-1:0] iter_count,
  input  logic              start,
  input  logic              halt,
  input  logic              fu_write_back,
  input  logic              fu_write_back_p,
  input  logic [31:0]       fu_outvalue,
  input  logic [3:0]        fu_outpred,
  output logic [7:0]        fu_op_mode,
  output logic              fu_imm,
  output logic [7:0]        fu_imm_val,
  output logic              fu_pred_control,
  output logic [3:0]        fu_pred,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              result_valid,
  output logic              dbg_state
);
  // Handshake: start is a level sampled only in IDLE; done and result_valid are
  // single-cycle pulses; halt is sampled only in RUN and wins over completion.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic [7:0] NOP = 8'hFF;

  state_t            state;
  logic [17:0]       ctx_mem [CTX_DEPTH];
  logic [3:0]        pc;
  logic [3:0]        len_q;
  logic [3:0]        pc_next;
  logic [ITER_W-1:0] iter;
  logic [ITER_W-1:0] iter_last;
  logic              last_issue;
  logic              wrap;
  logic [17:0]       next_word;

  assign dbg_state = (state == RUN);

  // Configuration is only accepted while idle and not launching in the same cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && !start && cfg_we) ctx_mem[cfg_addr] <= cfg_data;
  end

  always_comb begin
    wrap       = (pc == len_q);
    last_issue = wrap && (iter == iter_last);
    pc_next    = wrap ? 4'd0 : pc + 4'd1;
    next_word  = ctx_mem[pc_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc              <= 4'd0;
      iter            <= '0;
      len_q           <= 4'd0;
      iter_last       <= '0;
      fu_op_mode      <= NOP;
      fu_imm          <= 1'b0;
      fu_imm_val      <= 8'd0;
      fu_pred_control <= 1'b0;
      fu_pred         <= 4'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      result          <= 32'd0;
      result_valid    <= 1'b0;
    end else begin
      done         <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            pc        <= 4'd0;
            iter      <= '0;
            len_q     <= ctx_len;
            // An iteration count of zero runs the body once.
            iter_last <= (iter_count == '0) ? '0 : iter_count - ITER_W'(1);
            {fu_pred_control, fu_imm, fu_imm_val, fu_op_mode} <= ctx_mem[4'd0];
          end
        end
        RUN: begin
          // The FU is combinational, so its results belong to the word issued this cycle.
          if (fu_op_mode != NOP) begin
            if (fu_write_back) begin
              result       <= fu_outvalue;
              result_valid <= 1'b1;
            end
            if (fu_write_back_p) fu_pred <= fu_outpred;
          end
          if (halt || last_issue) begin
            state           <= IDLE;
            busy            <= 1'b0;
            pc              <= 4'd0;
            iter            <= '0;
            fu_op_mode      <= NOP;
            fu_imm          <= 1'b0;
            fu_imm_val      <= 8'd0;
            fu_pred_control <= 1'b0;
            done            <= !halt;
          end else begin
            pc <= pc_next;
            if (wrap) iter <= iter + ITER_W'(1);
            {fu_pred_control, fu_imm, fu_imm_val, fu_op_mode} <= next_word;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Bench for pe_ctx_sequencer: table-driven runs, hand-written corner sequences and
// randomized runs checked against an issue-sequence model built from the loop rules.
module tb_pe_ctx_sequencer;
  localparam int ITER_W = 16;
  localparam logic [17:0] NOP_WORD = 18'h000FF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [17:0]       cfg_data;
  logic [3:0]        ctx_len;
  logic [ITER_W-1:0] iter_count;
  logic              start, halt;
  logic              fu_write_back, fu_write_back_p;
  logic [31:0]       fu_outvalue;
  logic [3:0]        fu_outpred;
  logic [7:0]        fu_op_mode;
  logic              fu_imm;
  logic [7:0]        fu_imm_val;
  logic              fu_pred_control;
  logic [3:0]        fu_pred;
  logic              busy, done, result_valid, dbg_state;
  logic [31:0]       result;

  pe_ctx_sequencer #(.CTX_DEPTH(16), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .ctx_len(ctx_len), .iter_count(iter_count), .start(start), .halt(halt),
    .fu_write_back(fu_write_back), .fu_write_back_p(fu_write_back_p),
    .fu_outvalue(fu_outvalue), .fu_outpred(fu_outpred),
    .fu_op_mode(fu_op_mode), .fu_imm(fu_imm), .fu_imm_val(fu_imm_val),
    .fu_pred_control(fu_pred_control), .fu_pred(fu_pred), .busy(busy), .done(done),
    .result(result), .result_valid(result_valid), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [17:0] exp_q[$];
  logic [17:0] ctx_model [16];
  logic [31:0] exp_result;
  logic [3:0]  exp_pred;
  logic        exp_rv;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int len; int ic; int halt_at; bit chain; int exp_busy; bit exp_done;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] fu_word();
    return {fu_pred_control, fu_imm, fu_imm_val, fu_op_mode};
  endfunction

  // driver: writes one context entry; entered and left at a negedge
  task automatic write_ctx(input logic [3:0] a, input logic [17:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    ctx_model[a] = d;
    @(negedge clk);
  endtask

  function automatic logic [17:0] rand_word();
    logic [17:0] w;
    w = 18'($urandom);
    if ($urandom_range(0, 3) == 0) w[7:0] = 8'hFF;
    return w;
  endfunction

  // driver: one full run, checked cycle by cycle against the expected issue queue
  task automatic do_run(input int len, input int ic, input int halt_at, input bit chain,
                        input bit rnd, output int busy_seen, output int done_seen);
    int n_iss, n_eff;
    bit halted, wb, wbp;
    logic [31:0] val;
    logic [3:0]  pin;
    logic [17:0] w;
    n_iss  = (len + 1) * ((ic == 0) ? 1 : ic);
    halted = (halt_at >= 0) && (halt_at < n_iss);
    n_eff  = halted ? halt_at + 1 : n_iss;
    exp_q.delete();
    for (int k = 0; k < n_eff; k++) exp_q.push_back(ctx_model[k % (len + 1)]);
    busy_seen = 0;
    if (!chain) begin @(posedge clk); #1; end
    start = 1'b1; halt = 1'($urandom); ctx_len = 4'(len); iter_count = ITER_W'(ic);
    @(posedge clk); #1;
    start = 1'b0; ctx_len = 4'($urandom); iter_count = ITER_W'($urandom);
    exp_rv = 1'b0;
    for (int k = 0; k < n_eff; k++) begin
      wb  = rnd ? 1'($urandom) : 1'b0;
      wbp = rnd ? 1'($urandom) : 1'b0;
      val = $urandom;
      pin = 4'($urandom);
      fu_write_back = wb; fu_write_back_p = wbp; fu_outvalue = val; fu_outpred = pin;
      halt = (k == halt_at);
      start = 1'($urandom);
      cfg_we = 1'($urandom); cfg_addr = 4'($urandom); cfg_data = 18'($urandom);
      @(negedge clk);
      w = exp_q.pop_front();
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("fu_word", fu_word(), w);
      check("fu_pred_run", fu_pred, exp_pred);
      check("rv_run", result_valid, exp_rv);
      check("result_run", result, exp_result);
      busy_seen += int'(busy);
      exp_rv = wb && (w[7:0] != 8'hFF);
      if (exp_rv) exp_result = val;
      if (wbp && (w[7:0] != 8'hFF)) exp_pred = pin;
      @(posedge clk); #1;
    end
    start = 1'b0; halt = 1'b0; cfg_we = 1'b0; fu_write_back = 1'b0; fu_write_back_p = 1'b0;
    @(negedge clk);
    check("busy_end", busy, 0);
    check("done_end", done, 32'(!halted));
    check("fu_word_end", fu_word(), NOP_WORD);
    check("rv_end", result_valid, exp_rv);
    check("result_end", result, exp_result);
    check("fu_pred_end", fu_pred, exp_pred);
    check("state_end", dbg_state, 0);
    busy_seen += int'(busy);
    done_seen = int'(done);
    exp_rv = 1'b0;
  endtask

  initial begin
    int bs, ds, len, ic, n, ha;
    rst_n = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_data = 0; ctx_len = 0; iter_count = 0;
    start = 0; halt = 0; fu_write_back = 0; fu_write_back_p = 0; fu_outvalue = 0; fu_outpred = 0;
    exp_result = 0; exp_pred = 0; exp_rv = 0;
    vecs[0] = '{2, 3, -1, 1'b0, 9, 1'b1};
    vecs[1] = '{2, 3, 3, 1'b0, 4, 1'b0};
    vecs[2] = '{3, 0, -1, 1'b0, 4, 1'b1};
    vecs[3] = '{1, 4, 7, 1'b0, 8, 1'b0};
    vecs[4] = '{0, 1, -1, 1'b1, 1, 1'b1};
    vecs[5] = '{15, 2, -1, 1'b0, 32, 1'b1};
    vecs[6] = '{0, 0, -1, 1'b1, 1, 1'b1};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fu_word", fu_word(), NOP_WORD);
    check("rst_pred", fu_pred, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) write_ctx(4'(i), rand_word());

    // single pass: addi 5 producing 42
    write_ctx(4'd0, {1'b0, 1'b1, 8'd5, 8'h00});
    @(posedge clk); #1; start = 1; ctx_len = 0; iter_count = 1;
    @(posedge clk); #1; start = 0; fu_outvalue = 32'd42; fu_write_back = 1;
    @(negedge clk);
    check("p1_busy", busy, 1);
    check("p1_op", fu_op_mode, 8'h00);
    check("p1_imm_val", fu_imm_val, 8'd5);
    check("p1_imm", fu_imm, 1);
    @(posedge clk); #1; fu_write_back = 0;
    @(negedge clk);
    check("p1_done", done, 1);
    check("p1_busy_end", busy, 0);
    check("p1_result", result, 32'd42);
    check("p1_rv", result_valid, 1);
    check("p1_op_end", fu_op_mode, 8'hFF);
    exp_result = 32'd42;

    // predicate write by a compare op, then held through a run without writes
    write_ctx(4'd0, {1'b0, 1'b0, 8'h00, 8'h20});
    @(posedge clk); #1; start = 1; ctx_len = 0; iter_count = 1;
    @(posedge clk); #1; start = 0; fu_write_back_p = 1; fu_outpred = 4'h1;
    @(negedge clk);
    check("pw_op", fu_op_mode, 8'h20);
    check("pw_pred_before", fu_pred, 4'h0);
    @(posedge clk); #1; fu_write_back_p = 0;
    @(negedge clk);
    check("pw_pred", fu_pred, 4'h1);
    check("pw_done", done, 1);
    exp_pred = 4'h1;
    do_run(2, 2, -1, 1'b0, 1'b0, bs, ds);

    // table-driven runs
    for (int i = 0; i < 7; i++) begin
      do_run(vecs[i].len, vecs[i].ic, vecs[i].halt_at, vecs[i].chain, 1'b1, bs, ds);
      check($sformatf("vec%0d_busy_cycles", i), bs, vecs[i].exp_busy);
      check($sformatf("vec%0d_done", i), ds, 32'(vecs[i].exp_done));
    end

    // randomized runs
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) write_ctx(4'($urandom), rand_word());
      len = $urandom_range(0, 7);
      ic  = $urandom_range(0, 3);
      n   = (len + 1) * ((ic == 0) ? 1 : ic);
      ha  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n + 1) : -1;
      do_run(len, ic, ha, 1'($urandom), 1'b1, bs, ds);
    end

    // asynchronous reset mid-run
    @(posedge clk); #1; start = 1; ctx_len = 3; iter_count = 2;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mr_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_fu_word", fu_word(), NOP_WORD);
    check("mr_pred", fu_pred, 0);
    check("mr_result", result, 0);
    check("mr_rv", result_valid, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    exp_pred = 0; exp_result = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_no_done", done, 0);
      check("mr_idle", busy, 0);
    end
    do_run(1, 2, -1, 1'b0, 1'b1, bs, ds);
    check("mr_rerun_busy", bs, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pe_ctx_sequencer.md
PE_CTX_SEQUENCER -- requirements
Module: pe_ctx_sequencer

Interface
REQ-001 SHALL have parameter CTX_DEPTH, default 16: number of context entries; the address is 4 bits.
REQ-002 SHALL have parameter ITER_W, default 16: width of the iteration counter.
REQ-003 SHALL provide a single clock and an asynchronous active-low reset: `clk  in  1  clock` and `rst_n  in  1  async active-low reset`.
REQ-004 SHALL provide `cfg_we  in  1  context write strobe`.
REQ-005 SHALL provide `cfg_addr  in  4  context entry index`.
REQ-006 SHALL provide `cfg_data  in  18  context word`, packed as {pred_control[17], imm[16], imm_val[15:8], op_mode[7:0]}.
REQ-007 SHALL provide `ctx_len  in  4  index of the last entry`; a loop body has ctx_len+1 entries.
REQ-008 SHALL provide `iter_count  in  ITER_W  loop iterations`; a value of 0 is treated as 1.
REQ-009 SHALL provide `start  in  1  launch request` and `halt  in  1  synchronous abort`.
REQ-010 SHALL provide `fu_write_back  in  1`, `fu_write_back_p  in  1`, `fu_outvalue  in  32` and `fu_outpred  in  4`: FU result inputs.
REQ-011 SHALL provide `fu_op_mode  out  8`, `fu_imm  out  1`, `fu_imm_val  out  8`, `fu_pred_control  out  1` and `fu_pred  out  4`: FU control outputs.
REQ-012 SHALL provide `busy  out  1`, `done  out  1` (one-cycle pulse), `result  out  32` and `result_valid  out  1` (one-cycle pulse).

Function
REQ-013 SHALL hold a CTX_DEPTH x 18 context memory, written on a clk edge when cfg_we=1, state=IDLE and start=0; cfg_we in any other case SHALL be ignored.
REQ-014 SHALL implement the states IDLE and RUN.
- IDLE -> RUN on start=1.
- RUN -> IDLE after the last issue cycle, or on halt=1.
REQ-015 SHALL register all fu_* outputs; in IDLE, fu_op_mode=8'hFF (NOP) and fu_imm, fu_imm_val and fu_pred_control are 0.
REQ-016 SHALL drive ctx[0] on the fu_* outputs in the cycle after start is sampled, and ctx[pc] in each following RUN cycle, one entry per cycle (one issue cycle each).
REQ-017 SHALL advance pc each issue cycle; when pc=ctx_len it SHALL wrap pc to 0 and increment iter.
REQ-018 SHALL leave RUN after the issue cycle with pc=ctx_len and iter=max(iter_count,1)-1, so that busy stays high for exactly (ctx_len+1)*max(iter_count,1) cycles.
REQ-019 SHALL latch ctx_len and iter_count at start; changes to them during RUN SHALL have no effect.
REQ-020 SHALL sample the FU results on the clk edge that ends each issue cycle, because the FU is combinational.
REQ-021 SHALL load result with fu_outvalue and pulse result_valid in the next cycle when fu_write_back=1 and the issued op_mode is not 8'hFF.
REQ-022 SHALL load the 4-bit predicate register (driven on fu_pred) with fu_outpred when fu_write_back_p=1 and the issued op_mode is not 8'hFF.
REQ-023 SHALL hold the predicate register across runs; only reset clears it.
REQ-024 SHALL pulse done for one cycle in the cycle after the final issue cycle, with busy=0 and fu_op_mode=8'hFF in that same cycle.
REQ-025 SHALL treat halt=1 during RUN as an abort.
- The current issue cycle's results are still sampled.
- The next cycle is IDLE with NOP outputs and no done pulse.
- halt in IDLE has no effect.
REQ-026 SHALL ignore start during RUN.
REQ-027 SHALL allow a start sampled in the done cycle to launch a new run, with the first issue cycle in the following cycle.
REQ-028 SHALL give halt priority over completion when both occur on the same edge, so no done pulse is produced.

Reset
REQ-029 SHALL, while rst_n=0 and regardless of clk, force the following:
- state=IDLE, pc=0, iter=0.
- fu_op_mode=8'hFF; fu_imm, fu_imm_val and fu_pred_control = 0.
- predicate register=0, result=0.
- busy, done and result_valid = 0.
REQ-030 SHALL abandon any run in progress when reset is asserted mid-run, with no done pulse; the context memory contents need not be reset.

Verification
REQ-031 SHALL cover a single pass:
- Setup: ctx[0]={0,1,8'd5,8'h00} (addi 5), ctx_len=0, iter_count=1, fu_outvalue=42, fu_write_back=1.
- Response: busy for 1 cycle with fu_op_mode=00, fu_imm_val=5; then done=1, result=42, result_valid=1.
REQ-032 SHALL cover a looped run: ctx_len=2, iter_count=3 -> busy for 9 cycles; fu_op_mode follows the sequence ctx0,ctx1,ctx2 three times; one done pulse.
REQ-033 SHALL cover a predicate write: a compare op 8'h20 issued with fu_write_back_p=1 and fu_outpred=4'h1 -> fu_pred=4'h1 from the next cycle, unchanged through a later run with fu_write_back_p=0.
REQ-034 SHALL cover halt: halt asserted in the 4th issue cycle of a 9-cycle run -> IDLE next cycle, fu_op_mode=FF, no done pulse; a following start re-runs from ctx[0].
REQ-035 SHALL cover ignored configuration writes: cfg_we to addr 1 with data 0 during RUN -> ctx[1] unchanged on the next run; iter_count=0 -> behaves as 1.
REQ-036 SHALL cover mid-run reset: rst_n pulsed low mid-run -> all outputs at reset values immediately (asynchronously), no done pulse.
